// File: rtl/uibi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uibi_pkg
// Description : Shared encodings for the UIBI slave bridge: bus_mode values,
//               FSM state enum and response error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package uibi_pkg;

  // bus_mode encodings: fraction of the data word being accessed
  localparam logic [2:0] UIBI_MODE_FULL  = 3'b111;
  localparam logic [2:0] UIBI_MODE_HALF  = 3'b011;
  localparam logic [2:0] UIBI_MODE_QUART = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } uibi_state_e;

  // Outcome of a transaction; anything other than ERR_NONE raises bus_err
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } uibi_err_e;

endpackage
`default_nettype wire

// File: rtl/uibi_lane_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uibi_lane_decoder
// Description : Combinational decode of bus_mode and the address byte offset
//               into per-lane byte enables, plus misalignment / illegal-mode
//               flags. Works for any power-of-two lane count >= 4.
// Revision    : 1.0 - initial release
// ============================================================================
module uibi_lane_decoder
  import uibi_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int OFFS_W = $clog2(LANES)
) (
  input  logic [2:0]        mode_i,
  input  logic [OFFS_W-1:0] off_i,
  output logic [LANES-1:0]  be_o,
  output logic              misaligned_o,
  output logic              illegal_o
);

  // Access size in bytes, alignment test and contiguous lane window
  always_comb begin
    int sz;
    int off;
    sz           = 0;
    off          = int'(off_i);
    illegal_o    = 1'b0;
    be_o         = '0;
    case (mode_i)
      UIBI_MODE_FULL:  sz = LANES;
      UIBI_MODE_HALF:  sz = LANES / 2;
      UIBI_MODE_QUART: sz = LANES / 4;
      default:         illegal_o = 1'b1;
    endcase
    // sizes are powers of two, so the low offset bits must be clear
    misaligned_o = (sz != 0) && ((off & (sz - 1)) != 0);
    for (int i = 0; i < LANES; i++) begin
      be_o[i] = (i >= off) && (i < off + sz);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uibi_slave_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uibi_slave_bridge
// Description : UIBI slave-side bridge. Accepts one bus transaction, decodes
//               it to byte enables, runs a handshaked word access on the
//               memory port with a timeout and returns a one-cycle
//               bus_ready/bus_err with lane-masked read data.
// Revision    : 1.0 - initial release
// ============================================================================
module uibi_slave_bridge
  import uibi_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int ADDR_W  = 28,
  parameter  int TIMEOUT = 255,
  localparam int LANES   = XLEN / 8,
  localparam int OFFS_W  = $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [XLEN-1:0]          bus_dat_i,
  output logic [XLEN-1:0]          bus_dat_o,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_req,
  input  logic                     bus_wen,
  input  logic [2:0]               bus_mode,
  output logic                     bus_ready,
  output logic                     bus_err,
  output logic                     mem_req,
  output logic                     mem_wen,
  output logic [ADDR_W-OFFS_W-1:0] mem_addr,
  output logic [LANES-1:0]         mem_be,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic [XLEN-1:0]          mem_rdata,
  input  logic                     mem_ack
);

  localparam int WADDR_W = ADDR_W - OFFS_W;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Value of the counter during the last ACC cycle allowed to wait for ack
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  uibi_state_e         state_q, state_d;
  logic [WADDR_W-1:0]  waddr_q;
  logic                wen_q;
  logic [LANES-1:0]    be_q;
  logic [XLEN-1:0]     wdata_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  uibi_err_e           err_q, err_d;
  logic [XLEN-1:0]     dat_q, dat_d;
  logic                load;

  logic [LANES-1:0]    dec_be;
  logic                dec_mis;
  logic                dec_ill;
  logic [XLEN-1:0]     lane_mask;

  uibi_lane_decoder #(
    .LANES  (LANES),
    .OFFS_W (OFFS_W)
  ) u_dec (
    .mode_i       (bus_mode),
    .off_i        (bus_addr[OFFS_W-1:0]),
    .be_o         (dec_be),
    .misaligned_o (dec_mis),
    .illegal_o    (dec_ill)
  );

  // Expand the registered byte enables to a bit mask for read data
  for (genvar l = 0; l < LANES; l++) begin : g_lane_mask
    assign lane_mask[l*8 +: 8] = {8{be_q[l]}};
  end

  // Next-state, timeout counting and response generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    err_d   = ERR_NONE;
    dat_d   = '0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus_req) begin
          load = 1'b1;
          if (dec_mis || dec_ill) begin
            // rejected without touching the memory side
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = ERR_DECODE;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        if (mem_ack) begin
          // an ack in the final allowed cycle still wins over the timeout
          state_d = ST_RESP;
          ready_d = 1'b1;
          if (!wen_q) begin
            dat_d = mem_rdata & lane_mask;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        // bus_req is deliberately ignored here
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= ERR_NONE;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Request capture; held stable for the whole memory access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (load) begin
      waddr_q <= bus_addr[ADDR_W-1:OFFS_W];
      wen_q   <= bus_wen;
      be_q    <= dec_be;
      wdata_q <= bus_dat_i;
    end
  end

  assign mem_req   = (state_q == ST_ACC);
  assign mem_wen   = wen_q;
  assign mem_addr  = waddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  assign bus_ready = ready_q;
  assign bus_err   = (err_q != ERR_NONE);
  assign bus_dat_o = dat_q;

endmodule
`default_nettype wire
